// File: rtl/aes_pkg.sv
// Shared constants and helpers for the Rijndael ShiftRows datapath.
// Row offsets depend on the block width (NB columns), not on direction.
package aes_pkg;

    localparam int BYTE_W = 8;

    // Bit n set means NB = n is a legal Rijndael column count (4, 6 or 8).
    localparam logic [8:0] NB_LEGAL_SET = 9'b1_0101_0000;

    function automatic bit nb_is_legal(input int nb);
        if (nb < 0 || nb > 8) begin
            return 1'b0;
        end
        return NB_LEGAL_SET[nb];
    endfunction

    // Rotation distance, in bytes, applied to row r of an NB-column state.
    function automatic int row_offset(input int nb, input int r);
        case (r)
            0:       return 0;
            1:       return 1;
            2:       return (nb == 8) ? 3 : 2;
            default: return (nb == 8) ? 4 : 3;
        endcase
    endfunction

endpackage

// File: rtl/aes_shiftrows_perm.sv
// Purely combinational ShiftRows / InvShiftRows byte permutation.
// Column 0 sits in the most significant byte of each row.
module aes_shiftrows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic                 inv,
    input  logic [BYTE_W*NB-1:0] in_row0,
    input  logic [BYTE_W*NB-1:0] in_row1,
    input  logic [BYTE_W*NB-1:0] in_row2,
    input  logic [BYTE_W*NB-1:0] in_row3,
    output logic [BYTE_W*NB-1:0] out_row0,
    output logic [BYTE_W*NB-1:0] out_row1,
    output logic [BYTE_W*NB-1:0] out_row2,
    output logic [BYTE_W*NB-1:0] out_row3
);

    logic [3:0][BYTE_W*NB-1:0] w_in;
    logic [3:0][BYTE_W*NB-1:0] w_enc;
    logic [3:0][BYTE_W*NB-1:0] w_dec;

    assign w_in = {in_row3, in_row2, in_row1, in_row0};

    // Both directions are pure wiring; the mode bit only picks one per row.
    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam int OFF = row_offset(NB, r);
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int SRC_E = (c + OFF) % NB;
            localparam int SRC_D = (c + NB - OFF) % NB;
            assign w_enc[r][BYTE_W*(NB-c)-1 -: BYTE_W] =
                w_in[r][BYTE_W*(NB-SRC_E)-1 -: BYTE_W];
            assign w_dec[r][BYTE_W*(NB-c)-1 -: BYTE_W] =
                w_in[r][BYTE_W*(NB-SRC_D)-1 -: BYTE_W];
        end
    end

    assign out_row0 = inv ? w_dec[0] : w_enc[0];
    assign out_row1 = inv ? w_dec[1] : w_enc[1];
    assign out_row2 = inv ? w_dec[2] : w_enc[2];
    assign out_row3 = inv ? w_dec[3] : w_enc[3];

endmodule

// File: rtl/aes_shiftrows_pipe.sv
// One-cycle ShiftRows stage with an output register and a skid register,
// giving full throughput while keeping in_ready free of out_ready paths.
module aes_shiftrows_pipe
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [BYTE_W*NB-1:0] in_row0,
    input  logic [BYTE_W*NB-1:0] in_row1,
    input  logic [BYTE_W*NB-1:0] in_row2,
    input  logic [BYTE_W*NB-1:0] in_row3,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BYTE_W*NB-1:0] out_row0,
    output logic [BYTE_W*NB-1:0] out_row1,
    output logic [BYTE_W*NB-1:0] out_row2,
    output logic [BYTE_W*NB-1:0] out_row3,
    output logic [TAG_W-1:0]     out_tag
);

    if (!nb_is_legal(NB)) begin : g_nb_check
        $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
    end

    logic [3:0][BYTE_W*NB-1:0] w_perm;
    logic [3:0][BYTE_W*NB-1:0] r_out_rows;
    logic [3:0][BYTE_W*NB-1:0] r_skid_rows;
    logic [TAG_W-1:0]          r_out_tag;
    logic [TAG_W-1:0]          r_skid_tag;
    logic                      r_out_valid;
    logic                      r_skid_valid;

    logic w_accept;
    logic w_out_free;
    logic w_load_out_from_skid;
    logic w_load_out_from_in;
    logic w_load_skid;

    aes_shiftrows_perm #(
        .NB(NB)
    ) u_perm (
        .inv      (in_inv),
        .in_row0  (in_row0),
        .in_row1  (in_row1),
        .in_row2  (in_row2),
        .in_row3  (in_row3),
        .out_row0 (w_perm[0]),
        .out_row1 (w_perm[1]),
        .out_row2 (w_perm[2]),
        .out_row3 (w_perm[3])
    );

    // The skid register only fills when the output is stalled, so a full
    // skid implies a full output register and blocks new input.
    always_comb begin
        w_accept             = in_valid && !r_skid_valid;
        w_out_free           = !r_out_valid || out_ready;
        w_load_out_from_skid = !flush && r_skid_valid && out_ready;
        w_load_out_from_in   = !flush && w_accept && w_out_free;
        w_load_skid          = !flush && w_accept && !w_out_free;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_load_out_from_skid) begin
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_out_free) begin
                r_out_valid  <= w_accept;
            end
            if (w_load_skid) begin
                r_skid_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load_out_from_skid) begin
            r_out_rows <= r_skid_rows;
            r_out_tag  <= r_skid_tag;
        end else if (w_load_out_from_in) begin
            r_out_rows <= w_perm;
            r_out_tag  <= in_tag;
        end
        if (w_load_skid) begin
            r_skid_rows <= w_perm;
            r_skid_tag  <= in_tag;
        end
    end

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_out_valid;
    assign out_row0  = r_out_rows[0];
    assign out_row1  = r_out_rows[1];
    assign out_row2  = r_out_rows[2];
    assign out_row3  = r_out_rows[3];
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// Directed self-checking bench for aes_shiftrows_pipe at NB=4 and NB=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_aes_shiftrows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        flush4, in_valid4, in_ready4, in_inv4, out_valid4, out_ready4;
    logic [31:0] i4r0, i4r1, i4r2, i4r3, o4r0, o4r1, o4r2, o4r3;
    logic [3:0]  in_tag4, out_tag4;

    logic        flush8, in_valid8, in_ready8, in_inv8, out_valid8, out_ready8;
    logic [63:0] i8r0, i8r1, i8r2, i8r3, o8r0, o8r1, o8r2, o8r3;
    logic [3:0]  in_tag8, out_tag8;

    int n_checks = 0;
    int n_fail   = 0;

    aes_shiftrows_pipe #(.NB(4), .TAG_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_inv(in_inv4),
        .in_row0(i4r0), .in_row1(i4r1), .in_row2(i4r2), .in_row3(i4r3),
        .in_tag(in_tag4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_row0(o4r0), .out_row1(o4r1), .out_row2(o4r2), .out_row3(o4r3),
        .out_tag(out_tag4)
    );

    aes_shiftrows_pipe #(.NB(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush8),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_inv(in_inv8),
        .in_row0(i8r0), .in_row1(i8r1), .in_row2(i8r2), .in_row3(i8r3),
        .in_tag(in_tag8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_row0(o8r0), .out_row1(o8r1), .out_row2(o8r2), .out_row3(o8r3),
        .out_tag(out_tag8)
    );

    // Reference rotation for 4-column rows; offsets 0,1,2,3 by row.
    function automatic logic [31:0] ref_row4(input logic [31:0] x, input int r, input bit inv);
        int n;
        n = 8 * r;
        if (!inv) return (x << n) | (x >> (32 - n));
        else      return (x >> n) | (x << (32 - n));
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        flush4 = 0; in_valid4 = 0; in_inv4 = 0; out_ready4 = 1; in_tag4 = 0;
        i4r0 = 0; i4r1 = 0; i4r2 = 0; i4r3 = 0;
        flush8 = 0; in_valid8 = 0; in_inv8 = 0; out_ready8 = 1; in_tag8 = 0;
        i8r0 = 0; i8r1 = 0; i8r2 = 0; i8r3 = 0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid4 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid4 got=%b exp=0", out_valid4); end
        n_checks++;
        if (in_ready4 !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready4 got=%b exp=1", in_ready4); end
        n_checks++;
        if (out_valid8 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid8 got=%b exp=0", out_valid8); end
        n_checks++;
        if (in_ready8 !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready8 got=%b exp=1", in_ready8); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid4 !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_idle got=%b exp=0", out_valid4); end
    endtask

    task automatic test_encrypt4();
        @(negedge clk);
        in_valid4 = 1; in_inv4 = 0; in_tag4 = 4'h5;
        i4r0 = 32'h00010203; i4r1 = 32'h04050607; i4r2 = 32'h08090A0B; i4r3 = 32'h0C0D0E0F;
        @(negedge clk);
        in_valid4 = 0;
        n_checks++;
        if (out_valid4 !== 1'b1 || out_tag4 !== 4'h5) begin
            n_fail++; $display("[TB] FAIL enc4_valid_tag got=%b/%h exp=1/5", out_valid4, out_tag4);
        end
        n_checks++;
        if ({o4r0, o4r1, o4r2, o4r3} !== {32'h00010203, 32'h05060704, 32'h0A0B0809, 32'h0F0C0D0E}) begin
            n_fail++; $display("[TB] FAIL enc4_rows got=%h %h %h %h exp=00010203 05060704 0A0B0809 0F0C0D0E", o4r0, o4r1, o4r2, o4r3);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid4 !== 1'b0) begin n_fail++; $display("[TB] FAIL enc4_drained got=%b exp=0", out_valid4); end
    endtask

    task automatic test_decrypt4();
        @(negedge clk);
        in_valid4 = 1; in_inv4 = 1; in_tag4 = 4'hA;
        i4r0 = 32'h00010203; i4r1 = 32'h04050607; i4r2 = 32'h08090A0B; i4r3 = 32'h0C0D0E0F;
        @(negedge clk);
        in_valid4 = 0;
        n_checks++;
        if (out_valid4 !== 1'b1 || out_tag4 !== 4'hA) begin
            n_fail++; $display("[TB] FAIL dec4_valid_tag got=%b/%h exp=1/a", out_valid4, out_tag4);
        end
        n_checks++;
        if ({o4r0, o4r1, o4r2, o4r3} !== {32'h00010203, 32'h07040506, 32'h0A0B0809, 32'h0D0E0F0C}) begin
            n_fail++; $display("[TB] FAIL dec4_rows got=%h %h %h %h exp=00010203 07040506 0A0B0809 0D0E0F0C", o4r0, o4r1, o4r2, o4r3);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back_nb8();
        @(negedge clk);
        in_valid8 = 1; in_inv8 = 0; in_tag8 = 4'h1;
        i8r0 = 64'h0123456789ABCDEF; i8r1 = 64'hFEDCBA9876543210;
        i8r2 = 64'h8899AABBCCDDEEFF; i8r3 = 64'h0011223344556677;
        @(negedge clk);
        n_checks++;
        if ({o8r0, o8r1, o8r2, o8r3} !== {64'h0123456789ABCDEF, 64'hDCBA9876543210FE,
                                          64'hBBCCDDEEFF8899AA, 64'h4455667700112233} || out_valid8 !== 1'b1) begin
            n_fail++; $display("[TB] FAIL nb8_encrypt got=%b %h %h %h %h", out_valid8, o8r0, o8r1, o8r2, o8r3);
        end
        in_inv8 = 1; in_tag8 = 4'h2;
        i8r0 = 64'h0123456789ABCDEF; i8r1 = 64'hDCBA9876543210FE;
        i8r2 = 64'hBBCCDDEEFF8899AA; i8r3 = 64'h4455667700112233;
        @(negedge clk);
        in_valid8 = 0;
        n_checks++;
        if ({o8r0, o8r1, o8r2, o8r3} !== {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                          64'h8899AABBCCDDEEFF, 64'h0011223344556677} || out_tag8 !== 4'h2) begin
            n_fail++; $display("[TB] FAIL nb8_roundtrip got=%h %h %h %h tag=%h", o8r0, o8r1, o8r2, o8r3, out_tag8);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int got = 0;
        int next_tag;
        bit accepted;
        @(negedge clk);
        out_ready4 = 0; in_valid4 = 1; in_inv4 = 0; next_tag = 1; in_tag4 = 4'd1;
        i4r0 = 32'h11111111; i4r1 = 32'h01020304; i4r2 = 32'h05060708; i4r3 = 32'h090A0B0C;
        @(negedge clk);
        n_checks++;
        if (in_ready4 !== 1'b1 || out_tag4 !== 4'd1) begin
            n_fail++; $display("[TB] FAIL bp_first_accept in_ready=%b tag=%h exp=1/1", in_ready4, out_tag4);
        end
        next_tag = 2; in_tag4 = 4'd2;
        @(negedge clk);
        n_checks++;
        if (in_ready4 !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready_drop got=%b exp=0", in_ready4); end
        next_tag = 3; in_tag4 = 4'd3;
        @(negedge clk);
        n_checks++;
        if (in_ready4 !== 1'b0 || out_valid4 !== 1'b1 || out_tag4 !== 4'd1 || o4r1 !== 32'h02030401) begin
            n_fail++; $display("[TB] FAIL bp_stall_stable in_ready=%b valid=%b tag=%h row1=%h", in_ready4, out_valid4, out_tag4, o4r1);
        end
        out_ready4 = 1;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            if (out_valid4 && out_ready4) begin
                got++;
                n_checks++;
                if (out_tag4 !== got[3:0]) begin
                    n_fail++; $display("[TB] FAIL bp_order got=%h exp=%h", out_tag4, got[3:0]);
                end
            end
            accepted = in_valid4 && in_ready4;
            @(negedge clk);
            if (accepted) begin
                if (next_tag == 3) in_valid4 = 0;
                else begin next_tag++; in_tag4 = next_tag[3:0]; end
            end
        end
        n_checks++;
        if (got != 3 || out_valid4 !== 1'b0) begin
            n_fail++; $display("[TB] FAIL bp_count got=%0d valid=%b exp=3/0", got, out_valid4);
        end
        in_valid4 = 0;
    endtask

    task automatic fill_both4();
        @(negedge clk);
        out_ready4 = 0; in_valid4 = 1; in_tag4 = 4'd7;
        @(negedge clk);
        in_tag4 = 4'd8;
        @(negedge clk);
        in_valid4 = 0;
        n_checks++;
        if (in_ready4 !== 1'b0 || out_valid4 !== 1'b1) begin
            n_fail++; $display("[TB] FAIL fill_both in_ready=%b valid=%b exp=0/1", in_ready4, out_valid4);
        end
    endtask

    task automatic test_reset_and_flush();
        fill_both4();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            n_fail++; $display("[TB] FAIL midreset_async valid=%b in_ready=%b exp=0/1", out_valid4, in_ready4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready4 = 1;
        @(negedge clk);
        n_checks++;
        if (out_valid4 !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_no_pulse got=%b exp=0", out_valid4); end
        fill_both4();
        flush4 = 1; in_valid4 = 1; in_tag4 = 4'd9;
        #1;
        n_checks++;
        if (out_valid4 !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_is_sync got=%b exp=1", out_valid4); end
        @(negedge clk);
        flush4 = 0; in_valid4 = 0;
        n_checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            n_fail++; $display("[TB] FAIL flush_clear valid=%b in_ready=%b exp=0/1", out_valid4, in_ready4);
        end
        out_ready4 = 1;
        @(negedge clk);
        n_checks++;
        if (out_valid4 !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_input_ignored got=%b exp=0", out_valid4); end
    endtask

    task automatic test_stream();
        logic [31:0] exp0, exp1, exp2, exp3;
        logic [3:0]  exp_tag;
        int received = 0;
        out_ready4 = 1;
        @(negedge clk);
        for (int i = 0; i <= 100; i++) begin
            if (i > 0) begin
                if (out_valid4 === 1'b1) received++;
                n_checks++;
                if (out_valid4 !== 1'b1 || {o4r0, o4r1, o4r2, o4r3, out_tag4} !== {exp0, exp1, exp2, exp3, exp_tag}) begin
                    n_fail++;
                    $display("[TB] FAIL stream_blk%0d got=%b %h %h %h %h %h exp=1 %h %h %h %h %h",
                             i - 1, out_valid4, o4r0, o4r1, o4r2, o4r3, out_tag4, exp0, exp1, exp2, exp3, exp_tag);
                end
            end
            if (i < 100) begin
                in_valid4 = 1;
                in_inv4   = 1'($urandom_range(0, 1));
                in_tag4   = i[3:0];
                i4r0 = $urandom; i4r1 = $urandom; i4r2 = $urandom; i4r3 = $urandom;
                exp0 = ref_row4(i4r0, 0, in_inv4);
                exp1 = ref_row4(i4r1, 1, in_inv4);
                exp2 = ref_row4(i4r2, 2, in_inv4);
                exp3 = ref_row4(i4r3, 3, in_inv4);
                exp_tag = i[3:0];
            end else begin
                in_valid4 = 0;
            end
            @(negedge clk);
        end
        n_checks++;
        if (received != 100) begin n_fail++; $display("[TB] FAIL stream_count got=%0d exp=100", received); end
    endtask

    initial begin
        test_reset();
        test_encrypt4();
        test_decrypt4();
        test_back_to_back_nb8();
        test_backpressure();
        test_reset_and_flush();
        test_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
